ps2_rx: RTL

PS2_RX -- requirements
Module: ps2_rx

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_clk_filter.sv | 54 +++++
 rtl/ps2_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Definitions shared by the PS/2 receiver and transmitter:
//   - ps2_state_e    : frame FSM state encoding
//   - PS2_FILTER_LEN : default length of the ps2c glitch filter
//   - PS2_DPS_BITS   : preload for the bit counter (data + parity + stop - 1)
//   - odd_parity()   : parity bit that makes data plus parity an odd count of ones
// ----------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } ps2_state_e;

  localparam int PS2_FILTER_LEN = 8;

  // 8 data + parity + stop = 10 edges, counted from 9 down to 0 inclusive.
  localparam logic [3:0] PS2_DPS_BITS = 4'd9;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ----------------------------------------------------------------------------
// ps2_clk_filter
// Debounces the asynchronous PS/2 clock line and produces a one-cycle tick on
// each falling edge of the filtered clock.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   ps2c       in   raw PS/2 clock line from the device
//   fall_edge  out  one-cycle pulse when the filtered clock goes 1 -> 0
//
// The shift register doubles as the synchronizer for ps2c: the filtered level
// only moves once FILTER_LEN consecutive samples agree, so a metastable first
// sample can at worst delay the decision by one cycle.
// ----------------------------------------------------------------------------
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic fall_edge
);

  logic [FILTER_LEN-1:0] filter_reg_q;
  logic [FILTER_LEN-1:0] filter_reg_d;
  logic                  filt_q;
  logic                  filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_reg_q <= '0;
      filt_q       <= 1'b0;
    end else begin
      filter_reg_q <= filter_reg_d;
      filt_q       <= filt_d;
    end
  end

  always_comb begin
    filter_reg_d = {ps2c, filter_reg_q[FILTER_LEN-1:1]};
    filt_d       = filt_q;
    if (filter_reg_q == '1) begin
      filt_d = 1'b1;
    end else if (filter_reg_q == '0) begin
      filt_d = 1'b0;
    end
  end

  assign fall_edge = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_rx.sv
// ----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver with glitch-filtered clock, parity and
// framing checks, and an inter-edge watchdog that abandons stalled frames.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   rx_en         in   permits a new frame to start; ignored once one has begun
//   ps2d          in   raw PS/2 data line
//   ps2c          in   raw PS/2 clock line
//   rx_idle       out  high while the FSM is idle
//   rx_done_tick  out  one-cycle pulse when a frame completes
//   dout          out  last received byte, valid from the cycle after the tick
//   par_err       out  odd-parity mismatch for dout
//   frm_err       out  stop bit was sampled 0 for dout
//   tout_tick     out  one-cycle pulse when the watchdog aborts a frame
//
// State  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a start bit (falling edge with ps2d low, rx_en high)
// DPS    | shifting in 8 data bits, parity and stop; watchdog running
// LOAD   | one cycle: rx_done_tick high, result registers load on exit
// ----------------------------------------------------------------------------
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN,
  parameter int TOUT_W     = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_en,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       rx_idle,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       par_err,
  output logic       frm_err,
  output logic       tout_tick
);

  localparam logic [TOUT_W-1:0] TOUT_ONE = {{(TOUT_W-1){1'b0}}, 1'b1};

  ps2_state_e        state_q, state_d;
  logic              ps2d_s1_q, ps2d_s1_d;
  logic              ps2d_s2_q, ps2d_s2_d;
  logic [3:0]        n_q, n_d;
  logic [9:0]        b_q, b_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [7:0]        dout_q, dout_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              fall_edge;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clk),
    .reset     (reset),
    .ps2c      (ps2c),
    .fall_edge (fall_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ps2d_s1_q <= 1'b0;
      ps2d_s2_q <= 1'b0;
      n_q       <= '0;
      b_q       <= '0;
      tout_q    <= '0;
      dout_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps2d_s1_q <= ps2d_s1_d;
      ps2d_s2_q <= ps2d_s2_d;
      n_q       <= n_d;
      b_q       <= b_d;
      tout_q    <= tout_d;
      dout_q    <= dout_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_comb begin
    ps2d_s1_d    = ps2d;
    ps2d_s2_d    = ps2d_s1_q;
    state_d      = state_q;
    n_d          = n_q;
    b_d          = b_q;
    tout_d       = '0;
    dout_d       = dout_q;
    par_err_d    = par_err_q;
    frm_err_d    = frm_err_q;
    rx_done_tick = 1'b0;
    tout_tick    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall_edge && rx_en && !ps2d_s2_q) begin
          n_d     = PS2_DPS_BITS;
          b_d     = '0;
          state_d = ST_DPS;
        end
      end

      ST_DPS: begin
        if (fall_edge) begin
          // LSB-first on the wire, so each bit enters at the top and the
          // whole frame ends up right-aligned: stop | parity | data[7:0].
          b_d = {ps2d_s2_q, b_q[9:1]};
          if (n_q == 4'd0) begin
            state_d = ST_LOAD;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (tout_q == '1) begin
          // Stalled device: drop the partial frame, results stay untouched.
          state_d   = ST_IDLE;
          tout_tick = 1'b1;
        end else begin
          tout_d = tout_q + TOUT_ONE;
        end
      end

      ST_LOAD: begin
        rx_done_tick = 1'b1;
        state_d      = ST_IDLE;
        dout_d       = b_q[7:0];
        par_err_d    = (b_q[8] != odd_parity(b_q[7:0]));
        frm_err_d    = ~b_q[9];
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rx_idle = (state_q == ST_IDLE);
  assign dout    = dout_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;

endmodule
